// File: rtl/exmem_stage.sv
// exmem_stage: registers ALU results, resolves branches, runs GP stores
// Ports: clk, rst (async, active low), in_* ALU slot with in_ready,
//   wb_* writeback, br_* fetch redirect, mem_* store handshake,
//   illegal_op; EXMEM_PERF_EN adds stall_cnt and flush_cnt.
module exmem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 7,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [REG_W-1:0]  in_branch,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_wren,
  output logic              wb_valid,
  output logic              wb_wren,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [OP_W-1:0]   wb_opcode,
  output logic              br_taken,
  output logic [REG_W-1:0]  br_target,
  output logic              illegal_op,
  output logic              mem_req,
  output logic [REG_W-1:0]  mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack
`ifdef EXMEM_PERF_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  localparam logic [OP_W-1:0] OP_ALU9 = OP_W'(9);
  localparam logic [OP_W-1:0] OP_B    = OP_W'(7);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_GP   = OP_W'(10);

  logic [0:0]        state_q, state_d;
  logic              ready_q, ready_d;
  logic              wbv_q, wbv_d;
  logic              wbw_q, wbw_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              br_q, br_d;
  logic [REG_W-1:0]  tgt_q, tgt_d;
  logic              ill_q, ill_d;
  logic              req_q, req_d;
  logic [REG_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;

  logic acc;
  logic is_nop, is_alu, is_b, is_beq, is_gp;

  // the slot right behind a taken branch is wrong-path
  assign acc    = in_valid & ready_q & ~br_q;
  assign is_nop = (in_opcode == '0);
  assign is_alu = (in_opcode >= OP_W'(1) && in_opcode <= OP_W'(6))
                | (in_opcode == OP_ALU9);
  assign is_b   = (in_opcode == OP_B);
  assign is_beq = (in_opcode == OP_BEQ);
  assign is_gp  = (in_opcode == OP_GP);

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    wbv_d   = 1'b0;
    wbw_d   = 1'b0;
    rd_d    = rd_q;
    data_d  = data_q;
    op_d    = op_q;
    br_d    = 1'b0;
    tgt_d   = tgt_q;
    ill_d   = 1'b0;
    req_d   = req_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    unique case (state_q)
      RUN: begin
        ready_d = 1'b1;
        if (acc) begin
          unique case (1'b1)
            is_nop: ;
            is_alu: begin
              wbv_d  = 1'b1;
              wbw_d  = in_wren;
              rd_d   = in_rd;
              data_d = in_result;
              op_d   = in_opcode;
            end
            is_b, is_beq: begin
              wbv_d  = 1'b1;
              rd_d   = in_rd;
              data_d = in_result;
              op_d   = in_opcode;
              // conditional form treats target 0 as not taken
              if (is_b || in_branch != '0) begin
                br_d  = 1'b1;
                tgt_d = in_branch;
              end
            end
            is_gp: begin
              req_d   = 1'b1;
              addr_d  = in_rd;
              wdat_d  = in_result;
              ready_d = 1'b0;
              state_d = MEM_WAIT;
            end
            default: ill_d = 1'b1;
          endcase
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          ready_d = 1'b1;
          wbv_d   = 1'b1;
          rd_d    = addr_q;
          data_d  = wdat_q;
          op_d    = OP_GP;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      ready_q <= 1'b0;
      wbv_q   <= 1'b0;
      wbw_q   <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      op_q    <= '0;
      br_q    <= 1'b0;
      tgt_q   <= '0;
      ill_q   <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      wbv_q   <= wbv_d;
      wbw_q   <= wbw_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      op_q    <= op_d;
      br_q    <= br_d;
      tgt_q   <= tgt_d;
      ill_q   <= ill_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
    end
  end

  assign in_ready   = ready_q;
  assign wb_valid   = wbv_q;
  assign wb_wren    = wbw_q;
  assign wb_rd      = rd_q;
  assign wb_data    = data_q;
  assign wb_opcode  = op_q;
  assign br_taken   = br_q;
  assign br_target  = tgt_q;
  assign illegal_op = ill_q;
  assign mem_req    = req_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdat_q;

`ifdef EXMEM_PERF_EN
  logic [15:0] stall_q, flush_q;
  logic        flush;

  assign flush = in_valid & ready_q & br_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (state_q == MEM_WAIT && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
      if (flush && flush_q != 16'hFFFF)
        flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_exmem_stage.sv
// tb_exmem_stage: directed scenarios plus a randomized run against
// a behavioural model of the EX/MEM stage.
module tb_exmem_stage;
  localparam int DW = 32;
  localparam int RW = 7;
  localparam int OW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [OW-1:0] in_opcode = '0;
  logic [RW-1:0] in_rd = '0;
  logic [RW-1:0] in_branch = '0;
  logic [DW-1:0] in_result = '0;
  logic          in_wren = 1'b0;
  logic          wb_valid, wb_wren;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic [OW-1:0] wb_opcode;
  logic          br_taken;
  logic [RW-1:0] br_target;
  logic          illegal_op;
  logic          mem_req;
  logic [RW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
`ifdef EXMEM_PERF_EN
  logic [15:0]   stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int failures = 0;

  exmem_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd),
    .in_branch(in_branch), .in_result(in_result),
    .in_wren(in_wren),
    .wb_valid(wb_valid), .wb_wren(wb_wren),
    .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_opcode(wb_opcode),
    .br_taken(br_taken), .br_target(br_target),
    .illegal_op(illegal_op),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack)
`ifdef EXMEM_PERF_EN
    ,
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input int op, input int rd,
                       input int br, input logic [DW-1:0] res,
                       input logic wr);
    in_valid  = 1'b1;
    in_opcode = OW'(op);
    in_rd     = RW'(rd);
    in_branch = RW'(br);
    in_result = res;
    in_wren   = wr;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_opcode = '0;
  endtask

  task automatic test_reset();
    logic [DW+RW*4+OW+8:0] all;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    all = {in_ready, wb_valid, wb_wren, wb_rd, wb_data, wb_opcode,
           br_taken, br_target, illegal_op, mem_req, mem_addr};
    checks++;
    if (all !== '0 || mem_wdata !== '0) begin
      failures++;
      $display("FAIL reset_outs got=%h exp=0", all);
    end
`ifdef EXMEM_PERF_EN
    checks++;
    if ({stall_cnt, flush_cnt} !== 32'h0) begin
      failures++;
      $display("FAIL reset_perf got=%h exp=0", {stall_cnt, flush_cnt});
    end
`endif
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_alu();
    drive(5, 3, 0, 32'h12, 1'b1);
    @(negedge clk);
    idle();
    checks++;
    if ({wb_valid, wb_wren, wb_rd, wb_data, wb_opcode} !==
        {1'b1, 1'b1, 7'd3, 32'h12, 5'd5}) begin
      failures++;
      $display("FAIL alu_wb got=%b%b %h %h %h exp=11 03 00000012 05",
               wb_valid, wb_wren, wb_rd, wb_data, wb_opcode);
    end
    @(negedge clk);
    checks++;
    if ({wb_valid, wb_wren} !== 2'b00) begin
      failures++;
      $display("FAIL alu_pulse got=%b exp=00", {wb_valid, wb_wren});
    end
  endtask

  task automatic test_branch();
    drive(8, 4, 'h2A, 32'h77, 1'b1);
    @(negedge clk);
    checks++;
    if ({br_taken, br_target, wb_valid, wb_wren} !==
        {1'b1, 7'h2A, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL beq_taken got=%b %h %b%b exp=1 2a 10",
               br_taken, br_target, wb_valid, wb_wren);
    end
    drive(5, 9, 0, 32'h99, 1'b1);
    @(negedge clk);
    idle();
    checks++;
    if ({br_taken, wb_valid, wb_wren} !== 3'b000) begin
      failures++;
      $display("FAIL flush_slot got=%b exp=000",
               {br_taken, wb_valid, wb_wren});
    end
`ifdef EXMEM_PERF_EN
    checks++;
    if (flush_cnt !== 16'd1) begin
      failures++;
      $display("FAIL flush_cnt got=%0d exp=1", flush_cnt);
    end
`endif
    drive(8, 4, 0, 32'h1, 1'b1);
    @(negedge clk);
    checks++;
    if ({br_taken, wb_valid, wb_wren} !== 3'b010) begin
      failures++;
      $display("FAIL beq_zero got=%b exp=010",
               {br_taken, wb_valid, wb_wren});
    end
    drive(7, 4, 0, 32'h1, 1'b1);
    @(negedge clk);
    idle();
    checks++;
    if ({br_taken, br_target, wb_valid, wb_wren} !==
        {1'b1, 7'h0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL b_zero got=%b %h %b%b exp=1 00 10",
               br_taken, br_target, wb_valid, wb_wren);
    end
    @(negedge clk);
  endtask

  task automatic test_store();
    drive(10, 'h10, 0, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    drive(5, 5, 0, 32'h55, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({mem_req, mem_addr, mem_wdata, in_ready, wb_valid} !==
          {1'b1, 7'h10, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL store_wait%0d got=%b %h %h %b%b", i,
                 mem_req, mem_addr, mem_wdata, in_ready, wb_valid);
      end
      if (i == 3) mem_ack = 1'b1;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    checks++;
    if ({mem_req, wb_valid, wb_wren, wb_opcode, in_ready} !==
        {1'b0, 1'b1, 1'b0, 5'd10, 1'b1}) begin
      failures++;
      $display("FAIL store_done got=%b%b%b %h %b exp=010 0a 1",
               mem_req, wb_valid, wb_wren, wb_opcode, in_ready);
    end
`ifdef EXMEM_PERF_EN
    checks++;
    if (stall_cnt !== 16'd4) begin
      failures++;
      $display("FAIL stall_cnt got=%0d exp=4", stall_cnt);
    end
`endif
    @(negedge clk);
    idle();
    mem_ack = 1'b1;
    checks++;
    if ({wb_valid, wb_rd, wb_data, wb_opcode} !==
        {1'b1, 7'd5, 32'h55, 5'd5}) begin
      failures++;
      $display("FAIL held_alu got=%b %h %h %h exp=1 05 00000055 05",
               wb_valid, wb_rd, wb_data, wb_opcode);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({wb_valid, mem_req} !== 2'b00) begin
      failures++;
      $display("FAIL stray_ack got=%b exp=00", {wb_valid, mem_req});
    end
  endtask

  task automatic test_reset_in_wait();
    drive(10, 'h22, 0, 32'h1234, 1'b0);
    @(negedge clk);
    idle();
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rw_req got=%b exp=1", mem_req);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_addr, mem_wdata, in_ready, wb_valid} !== '0) begin
      failures++;
      $display("FAIL rw_async got=%b %h %h %b%b", mem_req, mem_addr,
               mem_wdata, in_ready, wb_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, mem_req} !== 2'b10) begin
      failures++;
      $display("FAIL rw_release got=%b exp=10", {in_ready, mem_req});
    end
    drive(1, 6, 0, 32'h66, 1'b1);
    @(negedge clk);
    idle();
    checks++;
    if ({wb_valid, wb_rd} !== {1'b1, 7'd6}) begin
      failures++;
      $display("FAIL rw_run got=%b %h exp=1 06", wb_valid, wb_rd);
    end
  endtask

  task automatic test_nop_illegal();
    drive(0, 1, 0, 32'h1, 1'b1);
    @(negedge clk);
    drive(15, 2, 0, 32'h2, 1'b1);
    checks++;
    if ({wb_valid, illegal_op} !== 2'b00) begin
      failures++;
      $display("FAIL nop got=%b exp=00", {wb_valid, illegal_op});
    end
    @(negedge clk);
    idle();
    checks++;
    if ({wb_valid, wb_wren, illegal_op} !== 3'b001) begin
      failures++;
      $display("FAIL illegal got=%b exp=001",
               {wb_valid, wb_wren, illegal_op});
    end
    @(negedge clk);
    checks++;
    if (illegal_op !== 1'b0) begin
      failures++;
      $display("FAIL ill_pulse got=%b exp=0", illegal_op);
    end
  endtask

  task automatic test_back_to_back();
    int ops[4] = '{1, 2, 3, 9};
    logic [RW-1:0] rds[4];
    logic [DW-1:0] res[4];
    for (int i = 0; i < 4; i++) begin
      rds[i] = RW'($urandom);
      res[i] = $urandom;
    end
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        checks++;
        if ({wb_valid, wb_rd, wb_data, wb_opcode} !==
            {1'b1, rds[i-1], res[i-1], OW'(ops[i-1])}) begin
          failures++;
          $display("FAIL b2b%0d got=%b %h %h exp=1 %h %h", i - 1,
                   wb_valid, wb_rd, wb_data, rds[i-1], res[i-1]);
        end
      end
      if (i < 4) drive(ops[i], int'(rds[i]), 0, res[i], 1'b1);
      else idle();
      @(negedge clk);
    end
  endtask

  // expected outputs of the stage for the current cycle
  logic          e_ready, e_wbv, e_wbw, e_br, e_ill, e_req;
  logic [RW-1:0] e_rd, e_tgt, e_addr;
  logic [DW-1:0] e_data, e_wdata;
  logic [OW-1:0] e_op;
  int            m_stall, m_flush;

  task automatic mdl_tick();
    bit take;
    int op;
    take = in_valid && e_ready && !e_br;
    op = int'(in_opcode);
    if (in_valid && e_ready && e_br) m_flush++;
    e_wbv = 0; e_wbw = 0; e_br = 0; e_ill = 0;
    if (e_req) begin
      m_stall++;
      if (mem_ack) begin
        e_req = 0; e_ready = 1; e_wbv = 1; e_op = 5'd10;
      end
    end else begin
      e_ready = 1;
      if (take) begin
        if ((op >= 1 && op <= 6) || op == 9) begin
          e_wbv = 1; e_wbw = in_wren; e_op = in_opcode;
          e_rd = in_rd; e_data = in_result;
        end else if (op == 7 || op == 8) begin
          e_wbv = 1; e_op = in_opcode;
          if (op == 7 || in_branch != 0) begin
            e_br = 1; e_tgt = in_branch;
          end
        end else if (op == 10) begin
          e_req = 1; e_ready = 0;
          e_addr = in_rd; e_wdata = in_result;
        end else if (op != 0) begin
          e_ill = 1;
        end
      end
    end
  endtask

  task automatic test_random();
    int op;
    rst = 1'b0;
    idle();
    mem_ack = 1'b0;
    {e_ready, e_wbv, e_wbw, e_br, e_ill, e_req} = '0;
    m_stall = 0;
    m_flush = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 400; c++) begin
      checks++;
      if ({in_ready, wb_valid, wb_wren, br_taken, illegal_op, mem_req}
          !== {e_ready, e_wbv, e_wbw, e_br, e_ill, e_req}) begin
        failures++;
        $display("FAIL rnd_ctrl c=%0d got=%b exp=%b", c,
                 {in_ready, wb_valid, wb_wren, br_taken, illegal_op,
                  mem_req},
                 {e_ready, e_wbv, e_wbw, e_br, e_ill, e_req});
      end
      if (e_wbv) begin
        checks++;
        if (wb_opcode !== e_op ||
            (e_wbw && (wb_rd !== e_rd || wb_data !== e_data))) begin
          failures++;
          $display("FAIL rnd_wb c=%0d got=%h %h %h exp=%h %h %h", c,
                   wb_opcode, wb_rd, wb_data, e_op, e_rd, e_data);
        end
      end
      if (e_br) begin
        checks++;
        if (br_target !== e_tgt) begin
          failures++;
          $display("FAIL rnd_tgt c=%0d got=%h exp=%h", c,
                   br_target, e_tgt);
        end
      end
      if (e_req) begin
        checks++;
        if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin
          failures++;
          $display("FAIL rnd_mem c=%0d got=%h %h exp=%h %h", c,
                   mem_addr, mem_wdata, e_addr, e_wdata);
        end
      end
      op = ($urandom_range(0, 7) == 0) ? $urandom_range(11, 31)
                                       : $urandom_range(0, 10);
      if ($urandom_range(0, 3) == 0) idle();
      else drive(op, $urandom_range(0, 127),
                 ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 127),
                 $urandom, 1'($urandom));
      mem_ack = ($urandom_range(0, 2) == 0);
      mdl_tick();
      @(negedge clk);
    end
    idle();
    mem_ack = 1'b0;
`ifdef EXMEM_PERF_EN
    checks++;
    if (int'(stall_cnt) != m_stall || int'(flush_cnt) != m_flush) begin
      failures++;
      $display("FAIL rnd_perf got=%0d/%0d exp=%0d/%0d", stall_cnt,
               flush_cnt, m_stall, m_flush);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_store();
    test_reset_in_wait();
    test_nop_illegal();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exmem_stage.md
Name: exmem_stage

Overview:
- Execute-to-writeback pipeline stage directly downstream of the ALU.
- Registers ALU results (opcode, destination, result, write enable, branch target) and retires them to the register-file writeback port.
- Resolves branches B/BEG into a one-cycle redirect pulse and drops the wrong-path slot.
- Performs the GP store to data memory through a req/ack handshake, stalling upstream until acknowledged.

Parameters:
- DATA_W, 32, ALU result / store data width
- REG_W, 7, destination register / branch target / memory address width
- OP_W, 5, opcode width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  ALU slot holds a real instruction
- in_ready  out  1  stage accepts in_* this cycle
- in_opcode  in  OP_W  ALU OpCode output
- in_rd  in  REG_W  ALU RdOut
- in_branch  in  REG_W  ALU branchResult
- in_result  in  DATA_W  ALU AluResult
- in_wren  in  1  ALU Wrenable
- wb_valid  out  1  writeback slot valid (1-cycle pulse per retired instruction)
- wb_wren  out  1  register-file write strobe
- wb_rd  out  REG_W  writeback register index
- wb_data  out  DATA_W  writeback data
- wb_opcode  out  OP_W  retired opcode
- br_taken  out  1  redirect pulse to fetch
- br_target  out  REG_W  redirect PC
- illegal_op  out  1  1-cycle pulse, opcode > 10 accepted
- mem_req  out  1  store request
- mem_addr  out  REG_W  store address
- mem_wdata  out  DATA_W  store data
- mem_ack  in  1  store complete

Behaviour:
- Reset (rst low, async): all outputs 0, except in_ready, which is 0 while rst is low and 1 from the first clock after release. FSM = RUN. Any in-progress store is abandoned (mem_req drops immediately).
- Accept = in_valid & in_ready & ~br_taken. An accept while br_taken=1 is discarded: no wb, no store, no illegal_op (wrong-path flush).
- FSM RUN, in_ready=1. On accept, next cycle:
  - opcode 0: nothing retired (wb_valid=0).
  - opcodes 1-6, 9: wb_valid=1, wb_wren=in_wren, wb_rd=in_rd, wb_data=in_result, wb_opcode=in_opcode. Latency exactly 1 cycle.
  - opcode 7: br_taken=1, br_target=in_branch, regardless of target value. wb_valid=1, wb_wren=0.
  - opcode 8: br_taken=1 only if in_branch != 0; target 0 means not taken. wb_valid=1, wb_wren=0.
  - opcode 10 (GP): mem_req=1, mem_addr=in_rd, mem_wdata=in_result; FSM goes to MEM_WAIT.
  - opcode 11-31: illegal_op=1, wb_valid=0, treated as NOP.
- FSM MEM_WAIT:
  - in_ready=0. mem_req, mem_addr and mem_wdata are held stable.
  - The earliest mem_ack is honoured in the first cycle mem_req is high.
  - On mem_ack: next cycle mem_req=0, wb_valid=1, wb_wren=0, wb_opcode=10, in_ready=1, FSM back to RUN.
  - No timeout. mem_ack while mem_req=0 is ignored.
- Pulses: br_taken, wb_valid and illegal_op are single-cycle; all outputs are registered.
- Back-to-back: a new accept every cycle in RUN gives continuous 1-cycle retirement. A GP followed by an ALU op: the ALU op is held upstream (in_ready=0) and accepted the cycle after in_ready returns to 1.
- wb_wren is never asserted unless wb_valid is asserted.

Optional Feature:
- Macro: EXMEM_PERF_EN.
- Defined: adds output stall_cnt (16 bits). It increments every clock with FSM=MEM_WAIT, saturates at 0xFFFF and clears on reset. It also adds output flush_cnt (16 bits), which increments on each discarded wrong-path accept, saturating, clears on reset.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset release, then accept opcode 5, in_rd=3, in_result=0x0000_0012, in_wren=1 -> next cycle wb_valid=1, wb_wren=1, wb_rd=3, wb_data=0x12; the cycle after, wb_valid=0.
- Opcode 8 with in_branch=0x2A, followed by an opcode 5 accept on the next cycle -> br_taken=1, br_target=0x2A for one cycle; the opcode 5 is not retired. Opcode 8 with in_branch=0 -> br_taken stays 0, wb_valid=1, wb_wren=0.
- Opcode 10, in_rd=0x10, in_result=0xDEAD_BEEF, mem_ack held low 3 cycles then pulsed -> mem_req high 4 cycles with stable addr/data, in_ready=0 throughout; one cycle after ack, wb_valid=1, wb_opcode=10, in_ready=1. With EXMEM_PERF_EN: stall_cnt=4.
- Opcode 10, then rst asserted while in MEM_WAIT -> mem_req and all outputs go to 0 without waiting for a clock edge; after release, FSM is RUN and in_ready=1.
- Opcodes 0 and 15 accepted -> no wb_valid; illegal_op pulses once, for opcode 15 only.
- Opcodes 1, 2, 3, 9 issued on consecutive cycles -> four consecutive wb_valid pulses, each 1 cycle after its accept, in order, with the matching rd/data.
